// File: rtl/clock_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl_if
//
// Purpose:
//   Groups the signals exchanged between the time-setting sequencer and the
//   rest of the clock: button/tick pulses and the live counter value going in,
//   and the run gate, load strobe, edit values and display hints coming out.
//
// Signal summary:
//   tick_1hz            1  one-cycle pulse, once per second
//   btn_mode            1  debounced pulse: enter edit / advance field
//   btn_inc             1  debounced pulse: increment field
//   btn_dec             1  debounced pulse: decrement field
//   cur_hours           5  live counter hours (1..12 valid)
//   cur_mins            6  live counter minutes
//   cur_secs            6  live counter seconds
//   cur_ap              1  live AM(0)/PM(1)
//   run_en              1  counter count-enable
//   load                1  one-cycle parallel-load strobe to the counter
//   edit_hours          5  edit/load value, hours 1..12
//   edit_mins           6  edit/load value, minutes 0..59
//   edit_secs           6  edit/load value, seconds 0..59
//   edit_ap             1  edit/load value, AM/PM
//   field               2  0=none, 1=hours, 2=AM/PM, 3=minutes/seconds
//   blink               1  blink phase for the selected field
//   dbg_state           3  current sequencer state encoding (observation only)
//
// Handshake semantics: there is no valid/ready pair here. Every input is a
// single-cycle pulse sampled on the rising clock edge and is never held off.
// load is a single-cycle strobe; the counter must accept it on the cycle it is
// high, and edit_* are stable during that cycle.
//
// Modports:
//   master - the side that produces buttons/ticks/live time (system / bench)
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface clock_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [4:0] cur_hours;
    logic [5:0] cur_mins;
    logic [5:0] cur_secs;
    logic       cur_ap;
    logic       run_en;
    logic       load;
    logic [4:0] edit_hours;
    logic [5:0] edit_mins;
    logic [5:0] edit_secs;
    logic       edit_ap;
    logic [1:0] field;
    logic       blink;
    logic [2:0] dbg_state;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_dec,
        output cur_hours, cur_mins, cur_secs, cur_ap,
        input  run_en, load, edit_hours, edit_mins, edit_secs, edit_ap,
        input  field, blink, dbg_state
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_dec,
        input  cur_hours, cur_mins, cur_secs, cur_ap,
        output run_en, load, edit_hours, edit_mins, edit_secs, edit_ap,
        output field, blink, dbg_state
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Purpose:
//   Time-setting sequencer for the 12-hour time-of-day counter. A mode press
//   freezes the counter and copies the live time into edit registers; the user
//   then steps through hours, AM/PM and minutes with inc/dec, and a final mode
//   press issues a one-cycle parallel load back into the counter. Inactivity
//   for TIMEOUT_TICKS seconds abandons the edit without loading.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of clock_set_ctrl_if (buttons, tick, live time in;
//          run_en, load, edit_*, field, blink, dbg_state out)
//
// Parameters:
//   TIMEOUT_TICKS  inactivity timeout in tick_1hz pulses (0 disables)
//
// Build option:
//   CLOCK_SET_SECS_EN  when defined, a seconds-edit state follows the minutes
//                      state and the captured seconds are editable; when not
//                      defined, seconds are always loaded as 0.
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 30
) (
    input  logic             clk,
    input  logic             reset,
    clock_set_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_AP  = 3'd2,
        ST_SET_MIN = 3'd3,
        ST_SET_SEC = 3'd4,
        ST_COMMIT  = 3'd5
    } state_t;

    // The counter only ever holds 0..TIMEOUT_TICKS-1: the tick that would
    // reach TIMEOUT_TICKS aborts the edit and clears it instead.
    localparam int unsigned TW          = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);
    localparam bit          TO_EN       = (TIMEOUT_TICKS != 0);
    localparam int unsigned TO_LAST_INT = (TIMEOUT_TICKS > 0) ? (TIMEOUT_TICKS - 1) : 0;
    localparam logic [TW-1:0] TO_LAST   = TO_LAST_INT[TW-1:0];

    state_t        state_q, state_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    mins_q,  mins_d;
    logic [5:0]    secs_q,  secs_d;
    logic          ap_q,    ap_d;
    logic          blink_q, blink_d;
    logic [TW-1:0] to_q,    to_d;

    logic          inc_only;
    logic          dec_only;
    logic          any_btn;
    logic          expire;

    function automatic logic is_edit(input state_t s);
        return (s == ST_SET_HR) || (s == ST_SET_AP) ||
               (s == ST_SET_MIN) || (s == ST_SET_SEC);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            hours_q <= 5'd12;
            mins_q  <= 6'd0;
            secs_q  <= 6'd0;
            ap_q    <= 1'b0;
            blink_q <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            hours_q <= hours_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            ap_q    <= ap_d;
            blink_q <= blink_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hours_d  = hours_q;
        mins_d   = mins_q;
        secs_d   = secs_q;
        ap_d     = ap_q;

        // inc and dec together cancel; mode outranks both.
        inc_only = bus.btn_inc & ~bus.btn_dec;
        dec_only = bus.btn_dec & ~bus.btn_inc;
        any_btn  = bus.btn_mode | bus.btn_inc | bus.btn_dec;
        // Any button in the expiring tick's cycle keeps the edit alive.
        expire   = TO_EN && bus.tick_1hz && !any_btn && (to_q == TO_LAST);

        case (state_q)
            ST_RUN: begin
                if (bus.btn_mode) begin
                    // Out-of-range live values are sanitised on capture.
                    hours_d = ((bus.cur_hours >= 5'd1) && (bus.cur_hours <= 5'd12))
                              ? bus.cur_hours : 5'd12;
                    mins_d  = (bus.cur_mins <= 6'd59) ? bus.cur_mins : 6'd0;
`ifdef CLOCK_SET_SECS_EN
                    secs_d  = (bus.cur_secs <= 6'd59) ? bus.cur_secs : 6'd0;
`else
                    secs_d  = 6'd0;
`endif
                    ap_d    = bus.cur_ap;
                    state_d = ST_SET_HR;
                end
            end
            ST_SET_HR: begin
                if (bus.btn_mode) begin
                    state_d = ST_SET_AP;
                end else if (inc_only) begin
                    hours_d = (hours_q >= 5'd12) ? 5'd1 : hours_q + 5'd1;
                end else if (dec_only) begin
                    hours_d = (hours_q <= 5'd1) ? 5'd12 : hours_q - 5'd1;
                end
            end
            ST_SET_AP: begin
                if (bus.btn_mode) begin
                    state_d = ST_SET_MIN;
                end else if (inc_only || dec_only) begin
                    ap_d = ~ap_q;
                end
            end
            ST_SET_MIN: begin
                if (bus.btn_mode) begin
`ifdef CLOCK_SET_SECS_EN
                    state_d = ST_SET_SEC;
`else
                    state_d = ST_COMMIT;
`endif
                end else if (inc_only) begin
                    mins_d = (mins_q >= 6'd59) ? 6'd0 : mins_q + 6'd1;
                end else if (dec_only) begin
                    mins_d = (mins_q == 6'd0) ? 6'd59 : mins_q - 6'd1;
                end
            end
`ifdef CLOCK_SET_SECS_EN
            ST_SET_SEC: begin
                if (bus.btn_mode) begin
                    state_d = ST_COMMIT;
                end else if (inc_only) begin
                    secs_d = (secs_q >= 6'd59) ? 6'd0 : secs_q + 6'd1;
                end else if (dec_only) begin
                    secs_d = (secs_q == 6'd0) ? 6'd59 : secs_q - 6'd1;
                end
            end
`endif
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (is_edit(state_q) && expire) begin
            state_d = ST_RUN;
        end
    end

    // Inactivity counter: cleared by any button or any state change, counts
    // ticks only while an edit state is held.
    always_comb begin
        to_d = to_q;
        if (any_btn || (state_d != state_q)) begin
            to_d = '0;
        end else if (TO_EN && is_edit(state_q) && bus.tick_1hz) begin
            to_d = to_q + TW'(1);
        end
    end

    // Blink starts high on entry to any edit state so the newly selected field
    // is visible at once, then toggles once per second.
    always_comb begin
        blink_d = 1'b0;
        if (is_edit(state_d)) begin
            if (state_d != state_q) begin
                blink_d = 1'b1;
            end else if (bus.tick_1hz) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
            end
        end
    end

    always_comb begin
        bus.field = 2'd0;
        case (state_q)
            ST_SET_HR:  bus.field = 2'd1;
            ST_SET_AP:  bus.field = 2'd2;
            ST_SET_MIN: bus.field = 2'd3;
            ST_SET_SEC: bus.field = 2'd3;
            default:    bus.field = 2'd0;
        endcase
    end

    assign bus.run_en     = (state_q == ST_RUN);
    assign bus.load       = (state_q == ST_COMMIT);
    assign bus.edit_hours = hours_q;
    assign bus.edit_mins  = mins_q;
    assign bus.edit_secs  = secs_q;
    assign bus.edit_ap    = ap_q;
    assign bus.blink      = blink_q;
    assign bus.dbg_state  = state_q;

endmodule
